// File: rtl/neuron_pool_pkg.sv
// neuron_pool_pkg
//   Shared definitions for the time-multiplexed neuron pool sequencer.
//   Holds the 4-phase RAM strobe codes, the sequencer FSM state encoding
//   and a helper that turns the pool size exponent into a sweep length.
//   No ports; imported by the sequencer top level.
package neuron_pool_pkg;

  // Phase codes carried in the low two bits of neuron_counter.
  // PH_SPARE is the slot where the spike lines are sampled.
  localparam logic [1:0] PH_COUNT = 2'd0;
  localparam logic [1:0] PH_READ  = 2'd1;
  localparam logic [1:0] PH_SPARE = 2'd2;
  localparam logic [1:0] PH_WRITE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  // Number of rawclk cycles in one sweep: 2^(nn+1) neurons x 4 phases.
  function automatic int sweep_len(input int nn);
    return 1 << (nn + 3);
  endfunction

endpackage

// File: rtl/neuron_clk_div.sv
// neuron_clk_div
//   Programmable divider that derives a neuron clock from rawclk.
//   The output toggles every half_cnt+1 rawclk cycles, so the full period
//   is 2*(half_cnt+1). A single-cycle rise flag marks the rawclk edge on
//   which neuron_clk goes 0->1, letting downstream logic react on that
//   same edge instead of resynchronising the divided clock.
// Ports:
//   rawclk      in   sole clock
//   reset_sim   in   asynchronous active-high reset
//   enable      in   1 = count; 0 = hold divider state
//   half_cnt    in   half-period minus one, in rawclk cycles
//   neuron_clk  out  divided clock
//   rise        out  combinational flag: next edge drives neuron_clk 0->1
module neuron_clk_div (
  input  logic        rawclk,
  input  logic        reset_sim,
  input  logic        enable,
  input  logic [31:0] half_cnt,
  output logic        neuron_clk,
  output logic        rise
);

  logic [31:0] delay_cnt_q, delay_cnt_d;
  logic        neuron_clk_q, neuron_clk_d;
  logic        toggle;

  // Count up to half_cnt, then flip the clock and restart. Using a
  // "less than" test means that lowering half_cnt below the running count
  // simply forces a toggle on the next cycle rather than a long wrap.
  always_comb begin
    delay_cnt_d  = delay_cnt_q;
    neuron_clk_d = neuron_clk_q;
    toggle       = 1'b0;
    if (enable) begin
      if (delay_cnt_q < half_cnt) begin
        delay_cnt_d = delay_cnt_q + 32'd1;
      end else begin
        toggle       = 1'b1;
        neuron_clk_d = ~neuron_clk_q;
        delay_cnt_d  = '0;
      end
    end
  end

  // Divider state register.
  always_ff @(posedge rawclk or posedge reset_sim) begin
    if (reset_sim) begin
      delay_cnt_q  <= '0;
      neuron_clk_q <= 1'b0;
    end else begin
      delay_cnt_q  <= delay_cnt_d;
      neuron_clk_q <= neuron_clk_d;
    end
  end

  assign neuron_clk = neuron_clk_q;
  assign rise       = toggle & ~neuron_clk_q;

endmodule

// File: rtl/neuron_pool_sequencer.sv
// neuron_pool_sequencer
//   Time-multiplexing sequencer for an Izhikevich neuron pool. Each
//   neuron_clk rise starts one sweep over all 2^(NN+1) neurons, four rawclk
//   cycles per neuron, producing the RAM strobes for the neuron/synapse
//   datapath. Spike lines are sampled once per neuron and the per-channel
//   totals are published at the end of every sweep.
// Ports:
//   rawclk          in   sole clock
//   reset_sim       in   asynchronous active-high reset
//   enable          in   1 = run; 0 = freeze every register
//   half_cnt        in   neuron_clk half-period minus one
//   spikes_in       in   spike bit of the current neuron, per channel
//   neuron_clk      out  divided clock
//   neuron_counter  out  {neuron_index, phase}
//   neuron_index    out  index of the neuron being processed
//   write_count     out  phase 0 strobe
//   read_clock      out  phase 1 strobe
//   write_enable    out  phase 3 strobe
//   data_valid      out  first cycle of a sweep
//   spike_count     out  latched counts, channel k at [k*CW +: CW]
//   count_valid     out  one-cycle pulse when spike_count updates
//   overrun         out  sticky: neuron_clk rose while a sweep was busy
module neuron_pool_sequencer
  import neuron_pool_pkg::*;
#(
  parameter int NN  = 8,
  parameter int NCH = 2,
  parameter int CW  = NN + 2
) (
  input  logic              rawclk,
  input  logic              reset_sim,
  input  logic              enable,
  input  logic [31:0]       half_cnt,
  input  logic [NCH-1:0]    spikes_in,
  output logic              neuron_clk,
  output logic [NN+2:0]     neuron_counter,
  output logic [NN:0]       neuron_index,
  output logic              write_count,
  output logic              read_clock,
  output logic              write_enable,
  output logic              data_valid,
  output logic [NCH*CW-1:0] spike_count,
  output logic              count_valid,
  output logic              overrun
);

  localparam int            CNT_W     = NN + 3;
  localparam int            SWEEP_LEN = sweep_len(NN);
  localparam logic [NN+2:0] LAST_CNT  = CNT_W'(SWEEP_LEN - 1);

  seq_state_e        state_q, state_d;
  logic [NN+2:0]     counter_q, counter_d;
  logic [CW-1:0]     acc_q [NCH];
  logic [CW-1:0]     acc_d [NCH];
  logic [NCH*CW-1:0] spike_count_q, spike_count_d;
  logic              count_valid_q, count_valid_d;
  logic              overrun_q, overrun_d;
  logic              div_rise;
  logic              in_sweep;
  logic [1:0]        phase;

  neuron_clk_div u_div (
    .rawclk     (rawclk),
    .reset_sim  (reset_sim),
    .enable     (enable),
    .half_cnt   (half_cnt),
    .neuron_clk (neuron_clk),
    .rise       (div_rise)
  );

  // Sweep FSM, sampling and result publication. When enable is low every
  // register keeps its value, including count_valid, so a freeze is
  // completely transparent apart from stretching time. A rise that arrives
  // while a sweep is still busy only sets the sticky overrun flag; the
  // sweep in flight keeps its timing. Results are latched on the edge that
  // enters DONE, so count_valid is high for exactly the DONE cycle.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    acc_d         = acc_q;
    spike_count_d = spike_count_q;
    count_valid_d = count_valid_q;
    overrun_d     = overrun_q;
    if (enable) begin
      count_valid_d = 1'b0;
      if (div_rise && (state_q != ST_IDLE)) begin
        overrun_d = 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          counter_d = '0;
          if (div_rise) begin
            state_d = ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (counter_q[1:0] == PH_SPARE) begin
            for (int k = 0; k < NCH; k++) begin
              acc_d[k] = acc_q[k] + CW'(spikes_in[k]);
            end
          end
          if (counter_q == LAST_CNT) begin
            state_d       = ST_DONE;
            counter_d     = '0;
            count_valid_d = 1'b1;
            for (int k = 0; k < NCH; k++) begin
              spike_count_d[k*CW +: CW] = acc_q[k];
              acc_d[k]                  = '0;
            end
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          counter_d = '0;
        end
      endcase
    end
  end

  // State, counter, accumulator and result registers.
  always_ff @(posedge rawclk or posedge reset_sim) begin
    if (reset_sim) begin
      state_q       <= ST_IDLE;
      counter_q     <= '0;
      acc_q         <= '{default: '0};
      spike_count_q <= '0;
      count_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      acc_q         <= acc_d;
      spike_count_q <= spike_count_d;
      count_valid_q <= count_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  // Strobes are decoded from registered state only, so they hold their
  // last value during a freeze and are all low outside a sweep.
  assign in_sweep       = (state_q == ST_SWEEP);
  assign phase          = counter_q[1:0];
  assign neuron_counter = counter_q;
  assign neuron_index   = counter_q[NN+2:2];
  assign write_count    = in_sweep && (phase == PH_COUNT);
  assign read_clock     = in_sweep && (phase == PH_READ);
  assign write_enable   = in_sweep && (phase == PH_WRITE);
  assign data_valid     = in_sweep && (counter_q == '0);
  assign spike_count    = spike_count_q;
  assign count_valid    = count_valid_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_neuron_pool_sequencer.sv
// tb_neuron_pool_sequencer
//   Self-checking bench for neuron_pool_sequencer with NN=2 (8 neurons,
//   32-cycle sweeps) and two spike channels. Expected values come from
//   timing arithmetic relative to each neuron_clk rise and from the spike
//   patterns the bench itself drives.
module tb_neuron_pool_sequencer;

  localparam int NN    = 2;
  localparam int NCH   = 2;
  localparam int CW    = NN + 2;
  localparam int NNEUR = 8;
  localparam int SWEEP = 32;

  logic              rawclk = 1'b0;
  logic              reset_sim;
  logic              enable;
  logic [31:0]       half_cnt;
  logic [NCH-1:0]    spikes_in;
  logic              neuron_clk;
  logic [NN+2:0]     neuron_counter;
  logic [NN:0]       neuron_index;
  logic              write_count;
  logic              read_clock;
  logic              write_enable;
  logic              data_valid;
  logic [NCH*CW-1:0] spike_count;
  logic              count_valid;
  logic              overrun;

  int errors = 0;
  int checks = 0;

  // Stimulus state: 0 = constant spikes, 1 = single pulse on ch1 at
  // neuron 3, 2 = random per-neuron pattern with noise off the sample slot.
  int             spikeMode;
  logic [NCH-1:0] constSpikes;
  int             pulsePhase;
  logic [7:0]     pattern [NCH];
  logic           ovrModel;

  neuron_pool_sequencer #(.NN(NN), .NCH(NCH), .CW(CW)) dut (
    .rawclk         (rawclk),
    .reset_sim      (reset_sim),
    .enable         (enable),
    .half_cnt       (half_cnt),
    .spikes_in      (spikes_in),
    .neuron_clk     (neuron_clk),
    .neuron_counter (neuron_counter),
    .neuron_index   (neuron_index),
    .write_count    (write_count),
    .read_clock     (read_clock),
    .write_enable   (write_enable),
    .data_valid     (data_valid),
    .spike_count    (spike_count),
    .count_valid    (count_valid),
    .overrun        (overrun)
  );

  // Free-running raw clock.
  always #5 rawclk = ~rawclk;

  // Safety net in case something stalls outside a bounded wait.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge rawclk);
    #1;
  endtask

  // Drive spikes for the neuron_counter value cnt that the DUT holds
  // during the next rawclk edge.
  task automatic applyStimulus(input int cnt);
    int idx;
    int ph;
    idx = cnt / 4;
    ph  = cnt % 4;
    case (spikeMode)
      0: spikes_in = constSpikes;
      1: spikes_in = {(idx == 3) && (ph == pulsePhase), 1'b0};
      default: begin
        for (int ch = 0; ch < NCH; ch++) begin
          spikes_in[ch] = (ph == 2) ? pattern[ch][idx] : 1'($urandom_range(0, 1));
        end
      end
    endcase
  endtask

  function automatic int expCount(input int ch);
    case (spikeMode)
      0:       return constSpikes[ch] ? NNEUR : 0;
      1:       return (ch == 1 && pulsePhase == 2) ? 1 : 0;
      default: return $countones(pattern[ch]);
    endcase
  endfunction

  // Rawclk ticks from the DONE sample to the next accepted rise: the first
  // multiple of the period at or after relative edge 34.
  function automatic int nextWait(input int period);
    return (((34 + period - 1) / period) * period) - 32;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {neuron_clk, neuron_counter, neuron_index, write_count,
                      read_clock, write_enable, data_valid, spike_count,
                      count_valid, overrun}, 64'd0);
  endtask

  task automatic applyReset(input string tag);
    reset_sim = 1'b1;
    tick();
    tick();
    checkAllZero(tag);
    ovrModel  = 1'b0;
    reset_sim = 1'b0;
  endtask

  task automatic waitRise(input int expWait, input string tag);
    int   n;
    int   cvSeen;
    bit   found;
    logic prev;
    n      = 0;
    cvSeen = 0;
    found  = 1'b0;
    prev   = neuron_clk;
    while (n < 400 && !found) begin
      applyStimulus(0);
      tick();
      n++;
      if (count_valid === 1'b1) cvSeen++;
      if (prev === 1'b0 && neuron_clk === 1'b1) found = 1'b1;
      prev = neuron_clk;
    end
    checkOutput({tag, "_found"}, 64'(found), 64'd1);
    checkOutput({tag, "_wait"}, 64'(n), 64'(expWait));
    checkOutput({tag, "_idle_cv"}, 64'(cvSeen), 64'd0);
  endtask

  // Follows one sweep from the rise sample (k=1) to the DONE sample (k=33).
  // freezeAt drops enable for 5 cycles after sample k; abortAt pulses the
  // async reset mid-cycle after sample k and ends the sweep there.
  task automatic runSweep(input int h, input int freezeAt, input int abortAt,
                          input string tag);
    int period;
    period = 2 * (h + 1);
    for (int k = 1; k <= SWEEP + 1; k++) begin
      int r;
      if (k > 1) tick();
      r = k - 1;
      if (k > 1 && (r % period) == 0) ovrModel = 1'b1;
      checkOutput({tag, "_nclk"}, 64'(neuron_clk), 64'(((r / (h + 1)) % 2) == 0));
      checkOutput({tag, "_ovr"}, 64'(overrun), 64'(ovrModel));
      if (k <= SWEEP) begin
        int c;
        c = k - 1;
        checkOutput({tag, "_cnt"}, 64'(neuron_counter), 64'(c));
        checkOutput({tag, "_idx"}, 64'(neuron_index), 64'(c / 4));
        checkOutput({tag, "_strobes"},
                    64'({write_count, read_clock, write_enable, data_valid}),
                    64'({(c % 4) == 0, (c % 4) == 1, (c % 4) == 3, c == 0}));
        checkOutput({tag, "_cv_low"}, 64'(count_valid), 64'd0);
      end else begin
        checkOutput({tag, "_cv_high"}, 64'(count_valid), 64'd1);
        checkOutput({tag, "_ch0"}, 64'(spike_count[0 +: CW]), 64'(expCount(0)));
        checkOutput({tag, "_ch1"}, 64'(spike_count[CW +: CW]), 64'(expCount(1)));
        checkOutput({tag, "_done_cnt"}, 64'(neuron_counter), 64'd0);
        checkOutput({tag, "_done_strobes"},
                    64'({write_count, read_clock, write_enable, data_valid}), 64'd0);
      end
      if (k == abortAt) begin
        #3;
        reset_sim = 1'b1;
        #1;
        checkAllZero({tag, "_async_reset"});
        tick();
        tick();
        ovrModel  = 1'b0;
        reset_sim = 1'b0;
        return;
      end
      applyStimulus((k <= SWEEP) ? k - 1 : 0);
      if (k == freezeAt) begin
        enable = 1'b0;
        repeat (5) begin
          tick();
          checkOutput({tag, "_frz_cnt"}, 64'(neuron_counter), 64'(k - 1));
          checkOutput({tag, "_frz_nclk"}, 64'(neuron_clk), 64'(((r / (h + 1)) % 2) == 0));
          checkOutput({tag, "_frz_cv"}, 64'(count_valid), 64'd0);
        end
        enable = 1'b1;
      end
    end
  endtask

  initial begin
    int h;
    reset_sim   = 1'b1;
    enable      = 1'b1;
    half_cnt    = 32'd39;
    spikes_in   = '0;
    spikeMode   = 0;
    constSpikes = 2'b01;
    pulsePhase  = 2;
    ovrModel    = 1'b0;
    for (int ch = 0; ch < NCH; ch++) pattern[ch] = '0;

    tick();
    tick();
    tick();
    checkAllZero("reset_state");
    reset_sim = 1'b0;

    // Constant spikes on ch0, period 80.
    waitRise(40, "first_rise");
    runSweep(39, -1, -1, "const_a");
    waitRise(nextWait(80), "rise_b");
    runSweep(39, -1, -1, "const_b");

    // Single pulse on ch1: counted only in the sample phase.
    spikeMode  = 1;
    pulsePhase = 2;
    waitRise(nextWait(80), "rise_pulse2");
    runSweep(39, -1, -1, "pulse_ph2");
    pulsePhase = 1;
    waitRise(nextWait(80), "rise_pulse1");
    runSweep(39, -1, -1, "pulse_ph1");

    // Freeze for 5 cycles at counter 12; divider freezes as well, so the
    // following rise keeps its usual distance from the DONE sample.
    spikeMode   = 0;
    constSpikes = 2'b01;
    waitRise(nextWait(80), "rise_freeze");
    runSweep(39, 13, -1, "freeze");

    // Reset in the middle of a sweep with spikes on both channels.
    constSpikes = 2'b11;
    waitRise(nextWait(80), "rise_after_freeze");
    runSweep(39, -1, 21, "abort");
    constSpikes = 2'b01;
    waitRise(40, "rise_after_abort");
    runSweep(39, -1, -1, "post_abort");

    // Period 22 is shorter than a sweep: the second rise is an overrun.
    half_cnt = 32'd10;
    applyReset("ovr_reset");
    waitRise(11, "ovr_rise_a");
    runSweep(10, -1, -1, "ovr_a");
    waitRise(nextWait(22), "ovr_rise_b");
    runSweep(10, -1, -1, "ovr_b");

    // Random periods and random per-neuron spike patterns.
    for (int rep = 0; rep < 3; rep++) begin
      h        = $urandom_range(16, 45);
      half_cnt = 32'(h);
      applyReset("rand_reset");
      spikeMode = 2;
      for (int ch = 0; ch < NCH; ch++) pattern[ch] = 8'($urandom);
      waitRise(h + 1, "rand_rise_a");
      runSweep(h, -1, -1, "rand_a");
      for (int ch = 0; ch < NCH; ch++) pattern[ch] = 8'($urandom);
      waitRise(nextWait(2 * (h + 1)), "rand_rise_b");
      runSweep(h, -1, -1, "rand_b");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_pool_sequencer.md
Name: neuron_pool_sequencer

Overview:
Parametrised time-multiplexing sequencer for Izhikevich neuron pools. It generates the local neuron_clk from rawclk and half_cnt, and sweeps neuron_counter once per neuron_clk rising edge, producing the 4-phase RAM strobes used by Iz_neuron and synapse. It also samples NCH spike lines per neuron and publishes per-channel population spike counts once per sweep. It replaces per-pool ad-hoc clock dividers and external counters, and adds overrun detection and an enable/freeze mode.

Parameters:
NN, 8, pool size exponent; neurons per pool = 2^(NN+1); sweep length SWEEP_LEN = 2^(NN+3) rawclk cycles
NCH, 2, number of spike channels counted (e.g. Ia, II, MN)
CW, NN+2, per-channel count width; holds 0..2^(NN+1)

Ports:
rawclk  in  1  sole clock
reset_sim  in  1  asynchronous active-high reset
enable  in  1  1 = run; 0 = freeze divider, FSM and counters
half_cnt  in  32  neuron_clk half-period minus 1, in rawclk cycles
spikes_in  in  NCH  spike bit of current neuron, per channel
neuron_clk  out  1  divided clock
neuron_counter  out  NN+3  {neuron_index, phase}
neuron_index  out  NN+1  neuron_counter[NN+2:2]
write_count  out  1  phase==0 during SWEEP
read_clock  out  1  phase==1 during SWEEP
write_enable  out  1  phase==3 during SWEEP
data_valid  out  1  SWEEP and neuron_counter==0
spike_count  out  NCH*CW  latched per-channel counts; channel k at [k*CW +: CW]
count_valid  out  1  one-cycle pulse when spike_count updates
overrun  out  1  sticky; neuron_clk rose before previous sweep finished

Behaviour:
- Reset (async, any time incl. mid-sweep): all outputs 0, delay_cnt 0, accumulators 0, FSM IDLE.
- enable=0: every register holds; strobes keep their last value; no sampling.
- Divider: if delay_cnt < half_cnt, delay_cnt++; else toggle neuron_clk and clear delay_cnt. Period = 2*(half_cnt+1). If half_cnt is lowered below delay_cnt, toggle on the next cycle.
- rise = the divider toggle that drives neuron_clk 0->1; the FSM sees it on the same edge.
- FSM states IDLE, SWEEP, DONE:
  - IDLE: neuron_counter=0. On rise -> SWEEP with counter=0, so counter 0 and neuron_clk high appear together.
  - SWEEP: counter +1 per cycle. At counter==SWEEP_LEN-1 -> DONE and counter wraps to 0.
  - DONE: on entry, spike_count <= accumulators and count_valid=1 for this one cycle; accumulators clear; next state IDLE.
- Sampling: in SWEEP with phase==2, accumulator[k] += spikes_in[k]. This gives exactly one sample per neuron per sweep.
- Overrun: a rise while in SWEEP or DONE sets overrun (sticky until reset) and is ignored; no new sweep starts. Sweep timing is unaffected.
- Latency: count_valid is high SWEEP_LEN+1 rising rawclk edges after neuron_clk rises, i.e. during the cycle after the last sweep cycle.
- Width: accumulators are CW bits; the maximum 2^(NN+1) fits, so there is no saturation.

Decomposition:
- Shared package neuron_pool_pkg: phase codes PH_COUNT=0, PH_READ=1, PH_SPARE=2 (sample), PH_WRITE=3; FSM state encoding; function sweep_len(NN).
- One sub-module, neuron_clk_div: the rawclk/half_cnt divider with enable and async reset. It outputs neuron_clk and a rise pulse, and is reusable by other pools.

Test Plan:
- NN=2, NCH=2; assert reset_sim mid-run -> all outputs 0 immediately (async). Release with half_cnt=39 -> neuron_clk toggles every 40 rawclk; first rise at cycle 40.
- half_cnt=39, spikes_in=2'b01 constant -> count_valid pulses 33 cycles after each neuron_clk rise; spike_count ch0=8, ch1=0; neuron_counter walks 0..31 then holds 0.
- spikes_in[1] high only when neuron_index==3 and phase==2 -> ch1=1. Same pulse at phase 1 instead -> ch1=0.
- half_cnt=10 (period 22 < 33) -> overrun=1 on the second rise. That sweep still completes with count_valid once; the ignored rise produces no extra sweep.
- enable dropped for 5 cycles at counter=12 -> counter, neuron_clk and delay_cnt frozen; on resume counter=13 next; count_valid arrives 5 cycles late; counts unchanged.
- reset_sim pulsed at counter=20 with spikes present -> accumulators clear, no count_valid; the next sweep reports only its own spikes (ch0=8).
